jpeg_udp_packetizer: RTL and testbench
======================================

JPEG_UDP_PACKETIZER -- requirements
Module: jpeg_udp_packetizer

Interface
REQ-001 SHALL have parameter PAYLOAD_MAX, default 1024, maximum JPEG payload bytes per UDP packet (range 16..1400).
REQ-002 SHALL have parameter FIFO_AW, default 12, byte FIFO address width (depth 2**FIFO_AW), with 2**FIFO_AW >= 2*PAYLOAD_MAX.
REQ-003 SHALL have port clk  input  1  single clock for all logic; MJPEG byte stream and MAC UDP port both run on it.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_jpg_data  input  8  MJPEG encoder output byte.
REQ-006 SHALL have port i_jpg_valid  input  1  i_jpg_data valid this cycle.
REQ-007 SHALL have port i_jpg_done  input  1  one-cycle pulse marking end of JPEG frame; may coincide with a final valid byte.
REQ-008 SHALL have port i_mac_init_ready  input  1  MAC initialised; no request issued while low.
REQ-009 SHALL have port i_udp_busy  input  1  MAC transmitting a packet.
REQ-010 SHALL have port i_byte_pass  input  1  MAC consumed o_udp_data this cycle.
REQ-011 SHALL have port o_udp_tx_en  output  1  one-cycle packet start request.
REQ-012 SHALL have port o_udp_tx_de  output  1  o_udp_data valid.
REQ-013 SHALL have port o_udp_data  output  8  UDP payload byte.
REQ-014 SHALL have port o_udp_data_len  output  16  UDP payload length, stable from o_udp_tx_en until i_udp_busy falls.
REQ-015 SHALL have port o_ipv4_sign  output  16  IPv4 identification, +1 per packet, wraps 0xFFFF->0x0000.
REQ-016 SHALL have port o_overflow  output  1  sticky: a byte was dropped due to a full FIFO.
REQ-017 SHALL have port o_frame_cnt  output  16  number of frames fully sent; wraps.

Function
REQ-018 SHALL write each valid byte to the FIFO when not full; when full, SHALL drop it and set o_overflow.
REQ-019 SHALL count unsent bytes of the open frame; on i_jpg_done, SHALL latch that count, including a same-cycle byte, as tail_len and set tail_pend.
REQ-020 SHALL ignore i_jpg_done while tail_pend=1, setting o_overflow; the bytes stay in the open frame.
REQ-021 SHALL use FSM states IDLE, REQ, HDR, PAY, WAIT_END.
REQ-022 In IDLE, SHALL start a packet when i_mac_init_ready=1, i_udp_busy=0 and either (a) tail_pend=0 and FIFO count >= PAYLOAD_MAX, or (b) tail_pend=1; payload length = min(PAYLOAD_MAX, tail_len) in case (b), else PAYLOAD_MAX.
REQ-023 When tail_pend=1 and tail_len=0 (done with no bytes), SHALL send a header-only packet with the last flag set.
REQ-024 SHALL hold o_udp_tx_en high for exactly one cycle in REQ, with o_udp_data_len and o_ipv4_sign already valid, then enter HDR, or PAY if the header is compiled out.
REQ-025 HDR SHALL present 4 bytes in order: frame_id[7:0], pkt_idx[15:8], pkt_idx[7:0], flags (bit0 = last packet of frame, others 0).
REQ-026 In HDR/PAY, SHALL hold o_udp_tx_de=1 and advance to the next byte only on i_byte_pass; with no i_byte_pass, o_udp_data is held.
REQ-027 PAY SHALL pop one FIFO byte per i_byte_pass; after the final byte, SHALL deassert o_udp_tx_de and enter WAIT_END.
REQ-028 In WAIT_END, SHALL return to IDLE on the first cycle i_udp_busy=0, or after 65535 cycles as a timeout.
REQ-029 On the last packet of a frame, SHALL clear tail_pend, increment frame_id and o_frame_cnt, and zero pkt_idx; otherwise SHALL increment pkt_idx and reduce tail_len by the payload sent.
REQ-030 SHALL write and read the FIFO in the same cycle without loss; full/empty SHALL use an FIFO_AW+1-bit count.

Reset
REQ-031 On rst_n low, SHALL set state=IDLE, FIFO empty, and tail_pend, frame_id, pkt_idx, o_udp_tx_en, o_udp_tx_de, o_udp_data, o_udp_data_len, o_ipv4_sign, o_overflow and o_frame_cnt all to 0.
REQ-032 Reset mid-packet SHALL abort immediately, with no further tx_en/tx_de, and discard all buffered data.

Configuration
REQ-033 Macro JPEG_PKT_HDR_EN defined: the 4-byte header is sent and o_udp_data_len = payload+4.
REQ-034 Macro JPEG_PKT_HDR_EN undefined: no HDR state, raw payload only, o_udp_data_len = payload, and the empty-frame packet of REQ-023 is suppressed (tail_pend cleared silently).

Verification
REQ-035 SHALL cover: 2500-byte frame, default params, i_byte_pass every cycle -> 3 packets with lengths 1028/1028/456, pkt_idx 0/1/2, flags 0/0/1, o_frame_cnt=1.
REQ-036 SHALL cover: i_udp_busy high for 200 cycles while 1024 bytes are buffered -> o_udp_tx_en issued only after busy falls.
REQ-037 SHALL cover: 5000 bytes pushed with i_mac_init_ready=0 -> 4096 bytes stored, o_overflow=1, and no o_udp_tx_en pulse.
REQ-038 SHALL cover: i_jpg_done with 0 bytes -> one 4-byte packet with flags=0x01, and none when JPEG_PKT_HDR_EN is undefined.
REQ-039 SHALL cover: rst_n low during PAY byte 300 -> all outputs 0 in the same cycle and the FIFO empty after release.
REQ-040 SHALL cover: i_byte_pass applied every 3rd cycle -> o_udp_data changes only after each pass and the byte sequence matches the input stream.

Source files
------------

// File: rtl/jpeg_udp_packetizer.sv
// rtl/jpeg_udp_packetizer.sv - MJPEG byte stream to UDP payload packetizer; JPEG_PKT_HDR_EN enables the 4-byte packet header
module jpeg_udp_packetizer #(
    parameter int PAYLOAD_MAX = 1024,
    parameter int FIFO_AW     = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  i_jpg_data,
    input  logic        i_jpg_valid,
    input  logic        i_jpg_done,
    input  logic        i_mac_init_ready,
    input  logic        i_udp_busy,
    input  logic        i_byte_pass,
    output logic        o_udp_tx_en,
    output logic        o_udp_tx_de,
    output logic [7:0]  o_udp_data,
    output logic [15:0] o_udp_data_len,
    output logic [15:0] o_ipv4_sign,
    output logic        o_overflow,
    output logic [15:0] o_frame_cnt
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam logic [CW-1:0] PM   = CW'(PAYLOAD_MAX);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
`ifdef JPEG_PKT_HDR_EN
    localparam logic [15:0] HDR_LEN = 16'd4;
`else
    localparam logic [15:0] HDR_LEN = 16'd0;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
`ifdef JPEG_PKT_HDR_EN
        S_HDR      = 3'd2,
`endif
        S_PAY      = 3'd3,
        S_WAIT_END = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]      open_cnt_q, open_cnt_d;
    logic [CW-1:0]      tail_len_q, tail_len_d;
    logic               tail_pend_q, tail_pend_d;
    logic [CW-1:0]      pay_len_q, pay_len_d;
    logic               is_last_q, is_last_d;
    logic               from_tail_q, from_tail_d;
    logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
    logic [15:0]        to_cnt_q, to_cnt_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        ipv4_q, ipv4_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
`ifdef JPEG_PKT_HDR_EN
    logic [7:0]         frame_id_q, frame_id_d;
    logic [15:0]        pkt_idx_q, pkt_idx_d;
`endif

    logic [7:0]    mem [DEPTH];
    logic          wr_en, rd_en, in_xfer, start_ok, empty_skip, start_pkt, pkt_end;
    logic [CW-1:0] open_after, pay_sel;

    assign wr_en     = i_jpg_valid && (fifo_cnt_q != FULL);
    assign in_xfer   = (state_q == S_PAY)
`ifdef JPEG_PKT_HDR_EN
                     || (state_q == S_HDR)
`endif
                     ;
    assign rd_en     = (state_q == S_PAY) && i_byte_pass;
    assign start_ok  = i_mac_init_ready && !i_udp_busy && (tail_pend_q || (fifo_cnt_q >= PM));
`ifdef JPEG_PKT_HDR_EN
    assign empty_skip = 1'b0;
`else
    assign empty_skip = tail_pend_q && (tail_len_q == '0);
`endif
    assign start_pkt = (state_q == S_IDLE) && (state_d == S_REQ);
    assign pkt_end   = (state_q != S_WAIT_END) && (state_d == S_WAIT_END);

    // Byte storage; read side is the asynchronous head-of-queue
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= i_jpg_data;
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            open_cnt_q  <= '0;
            tail_len_q  <= '0;
            tail_pend_q <= 1'b0;
            pay_len_q   <= '0;
            is_last_q   <= 1'b0;
            from_tail_q <= 1'b0;
            byte_cnt_q  <= '0;
            to_cnt_q    <= '0;
            len_q       <= '0;
            ipv4_q      <= '0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
`ifdef JPEG_PKT_HDR_EN
            frame_id_q  <= '0;
            pkt_idx_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            open_cnt_q  <= open_cnt_d;
            tail_len_q  <= tail_len_d;
            tail_pend_q <= tail_pend_d;
            pay_len_q   <= pay_len_d;
            is_last_q   <= is_last_d;
            from_tail_q <= from_tail_d;
            byte_cnt_q  <= byte_cnt_d;
            to_cnt_q    <= to_cnt_d;
            len_q       <= len_d;
            ipv4_q      <= ipv4_d;
            overflow_q  <= overflow_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef JPEG_PKT_HDR_EN
            frame_id_q  <= frame_id_d;
            pkt_idx_q   <= pkt_idx_d;
`endif
        end
    end

    // Next-state logic for the packet sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!empty_skip && start_ok) state_d = S_REQ;
`ifdef JPEG_PKT_HDR_EN
            S_REQ:      state_d = S_HDR;
            S_HDR:      if (i_byte_pass && byte_cnt_q == CW'(3))
                            state_d = (pay_len_q == '0) ? S_WAIT_END : S_PAY;
`else
            S_REQ:      state_d = S_PAY;
`endif
            S_PAY:      if (i_byte_pass && byte_cnt_q == pay_len_q - CW'(1)) state_d = S_WAIT_END;
            S_WAIT_END: if (!i_udp_busy || to_cnt_q == 16'hFFFF) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // FIFO pointers, frame accounting and per-packet bookkeeping
    always_comb begin
        wr_ptr_d    = wr_ptr_q + FIFO_AW'(wr_en);
        rd_ptr_d    = rd_ptr_q + FIFO_AW'(rd_en);
        fifo_cnt_d  = fifo_cnt_q + CW'(wr_en) - CW'(rd_en);
        tail_len_d  = tail_len_q;
        tail_pend_d = tail_pend_q;
        pay_len_d   = pay_len_q;
        is_last_d   = is_last_q;
        from_tail_d = from_tail_q;
        len_d       = len_q;
        ipv4_d      = ipv4_q;
        overflow_d  = overflow_q;
        frame_cnt_d = frame_cnt_q;
`ifdef JPEG_PKT_HDR_EN
        frame_id_d  = frame_id_q;
        pkt_idx_d   = pkt_idx_q;
`endif
        // A full-size packet taken while no tail is pending consumes open-frame bytes
        open_after  = open_cnt_q + CW'(wr_en) - ((start_pkt && !tail_pend_q) ? PM : '0);
        open_cnt_d  = open_after;
        pay_sel     = (tail_pend_q && tail_len_q < PM) ? tail_len_q : PM;

        if (i_jpg_valid && !wr_en) overflow_d = 1'b1;
        // A second frame end before the previous tail is out merges the frames
        if (i_jpg_done) begin
            if (tail_pend_q) begin
                overflow_d = 1'b1;
            end else begin
                tail_len_d  = open_after;
                tail_pend_d = 1'b1;
                open_cnt_d  = '0;
            end
        end

        if (start_pkt) begin
            pay_len_d   = pay_sel;
            from_tail_d = tail_pend_q;
            is_last_d   = tail_pend_q && (tail_len_q <= PM);
            len_d       = 16'(pay_sel) + HDR_LEN;
        end
        if (state_q == S_REQ) ipv4_d = ipv4_q + 16'd1;

        if (pkt_end || (state_q == S_IDLE && empty_skip)) begin
            if (is_last_q || empty_skip) begin
                tail_pend_d = 1'b0;
                frame_cnt_d = frame_cnt_q + 16'd1;
`ifdef JPEG_PKT_HDR_EN
                frame_id_d  = frame_id_q + 8'd1;
                pkt_idx_d   = '0;
`endif
            end else begin
`ifdef JPEG_PKT_HDR_EN
                pkt_idx_d   = pkt_idx_q + 16'd1;
`endif
                if (from_tail_q) tail_len_d = tail_len_q - pay_len_q;
            end
        end

        if (state_d != state_q) byte_cnt_d = '0;
        else if (in_xfer && i_byte_pass) byte_cnt_d = byte_cnt_q + CW'(1);
        else byte_cnt_d = byte_cnt_q;

        to_cnt_d = (state_q == S_WAIT_END) ? to_cnt_q + 16'd1 : 16'd0;
    end

    // Output decode from the current state
    always_comb begin
        o_udp_tx_en    = (state_q == S_REQ);
        o_udp_tx_de    = 1'b0;
        o_udp_data     = 8'd0;
        o_udp_data_len = len_q;
        o_ipv4_sign    = ipv4_q;
        o_overflow     = overflow_q;
        o_frame_cnt    = frame_cnt_q;
        case (state_q)
`ifdef JPEG_PKT_HDR_EN
            S_HDR: begin
                o_udp_tx_de = 1'b1;
                case (byte_cnt_q[1:0])
                    2'd0:    o_udp_data = frame_id_q;
                    2'd1:    o_udp_data = pkt_idx_q[15:8];
                    2'd2:    o_udp_data = pkt_idx_q[7:0];
                    default: o_udp_data = {7'd0, is_last_q};
                endcase
            end
`endif
            S_PAY: begin
                o_udp_tx_de = 1'b1;
                o_udp_data  = mem[rd_ptr_q];
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_jpeg_udp_packetizer.sv
// tb/tb_jpeg_udp_packetizer.sv - directed self-checking bench for jpeg_udp_packetizer
module tb_jpeg_udp_packetizer;
    localparam int PM = 1024;
`ifdef JPEG_PKT_HDR_EN
    localparam int H = 4;
`else
    localparam int H = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  i_jpg_data;
    logic        i_jpg_valid, i_jpg_done, i_mac_init_ready, i_udp_busy, i_byte_pass;
    logic        o_udp_tx_en, o_udp_tx_de, o_overflow;
    logic [7:0]  o_udp_data;
    logic [15:0] o_udp_data_len, o_ipv4_sign, o_frame_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_txen = 0;
    int          n_hold_bad = 0;
    logic [15:0] exp_sign = 16'd0;
    logic [7:0]  rx_q [$];

    jpeg_udp_packetizer #(.PAYLOAD_MAX(PM), .FIFO_AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_jpg_data(i_jpg_data), .i_jpg_valid(i_jpg_valid), .i_jpg_done(i_jpg_done),
        .i_mac_init_ready(i_mac_init_ready), .i_udp_busy(i_udp_busy), .i_byte_pass(i_byte_pass),
        .o_udp_tx_en(o_udp_tx_en), .o_udp_tx_de(o_udp_tx_de), .o_udp_data(o_udp_data),
        .o_udp_data_len(o_udp_data_len), .o_ipv4_sign(o_ipv4_sign),
        .o_overflow(o_overflow), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_udp_tx_en) n_txen <= n_txen + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int seed, input int i);
        int v;
        v = i * 7 + seed * 29 + (i >> 8) * 3;
        return v[7:0];
    endfunction

    task automatic push(input int n, input int seed, input bit done);
        for (int i = 0; i < n; i++) begin
            i_jpg_valid = 1'b1;
            i_jpg_data  = byte_of(seed, i);
            i_jpg_done  = done && (i == n - 1);
            @(posedge clk); #1;
        end
        i_jpg_valid = 1'b0;
        i_jpg_done  = 1'b0;
    endtask

    task automatic pulse_done();
        i_jpg_done = 1'b1;
        @(posedge clk); #1;
        i_jpg_done = 1'b0;
    endtask

    task automatic check_payload(input int seed, input int n);
        int bad;
        bad = 0;
        check("payload_size", 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            if (rx_q[i] !== byte_of(seed, i)) bad++;
        check("payload_bytes_wrong", 32'(bad), 32'd0);
        rx_q.delete();
    endtask

    task automatic no_txen(input string tag, input int cycles);
        int base;
        base = n_txen;
        repeat (cycles) @(posedge clk);
        #1;
        check(tag, 32'(n_txen - base), 32'd0);
    endtask

    // MAC receiver model: accepts one packet, passing a byte every `period` de-cycles
    task automatic mac_rx(input int period, input int exp_len, input logic [31:0] exp_hdr,
                          input int stop_at, output bit stopped);
        int t, got, cyc;
        logic [31:0] hdr;
        logic [7:0]  prev_d;
        bit          prev_pass, prev_de;
        stopped = 1'b0;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!o_udp_tx_en && t < 6000);
        if (!o_udp_tx_en) begin
            check("txen_wait_timeout", 32'd0, 32'd1);
            return;
        end
        check("data_len", 32'(o_udp_data_len), 32'(exp_len));
        check("ipv4_sign", 32'(o_ipv4_sign), 32'(exp_sign));
        exp_sign  = exp_sign + 16'd1;
        i_udp_busy = 1'b1;
        got = 0; cyc = 0; t = 0; hdr = '0; prev_d = '0; prev_pass = 0; prev_de = 0;
        while (got < exp_len && t < 4 * exp_len + 50) begin
            @(posedge clk); #1; t++;
            i_byte_pass = 1'b0;
            if (o_udp_tx_de) begin
                if (prev_de && !prev_pass && o_udp_data !== prev_d) n_hold_bad++;
                prev_d  = o_udp_data;
                prev_de = 1'b1;
                if (stop_at >= 0 && got == stop_at) begin
                    stopped = 1'b1;
                    return;
                end
                if (cyc % period == 0) begin
                    if (got < H) hdr = {hdr[23:0], o_udp_data};
                    else rx_q.push_back(o_udp_data);
                    got++;
                    i_byte_pass = 1'b1;
                    prev_pass   = 1'b1;
                end else begin
                    prev_pass = 1'b0;
                end
                cyc++;
            end else begin
                prev_de = 1'b0;
                prev_pass = 1'b0;
            end
        end
        if (got < exp_len) check("bytes_passed", 32'(got), 32'(exp_len));
        @(posedge clk); #1;
        i_byte_pass = 1'b0;
        check("de_after_last", 32'(o_udp_tx_de), 32'd0);
`ifdef JPEG_PKT_HDR_EN
        check("header", hdr, exp_hdr);
`endif
        repeat (2) @(posedge clk);
        #1;
        i_udp_busy = 1'b0;
    endtask

    initial begin
        bit st;
        rst_n = 1'b0;
        i_jpg_data = '0; i_jpg_valid = 0; i_jpg_done = 0;
        i_mac_init_ready = 0; i_udp_busy = 0; i_byte_pass = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_tx_en", 32'(o_udp_tx_en), 32'd0);
        check("rst_tx_de", 32'(o_udp_tx_de), 32'd0);
        check("rst_data", 32'(o_udp_data), 32'd0);
        check("rst_len", 32'(o_udp_data_len), 32'd0);
        check("rst_sign", 32'(o_ipv4_sign), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);

        // 2500-byte frame streamed while packets drain
        i_mac_init_ready = 1'b1;
        fork
            push(2500, 1, 1'b1);
            begin
                mac_rx(1, PM + H, {8'd0, 16'd0, 8'd0}, -1, st);
                mac_rx(1, PM + H, {8'd0, 16'd1, 8'd0}, -1, st);
                mac_rx(1, 452 + H, {8'd0, 16'd2, 8'd1}, -1, st);
            end
        join
        check_payload(1, 2500);
        repeat (2) @(posedge clk);
        #1;
        check("frame_cnt_after_2500", 32'(o_frame_cnt), 32'd1);

        // MAC busy holds off the request while a full payload is buffered
        i_udp_busy = 1'b1;
        fork
            begin
                push(PM, 2, 1'b0);
                repeat (200) @(posedge clk);
                #1;
            end
            no_txen("txen_while_busy", PM + 200);
        join
        i_udp_busy = 1'b0;
        mac_rx(1, PM + H, {8'd1, 16'd0, 8'd0}, -1, st);
        check_payload(2, PM);
        pulse_done();
`ifdef JPEG_PKT_HDR_EN
        mac_rx(1, 4, {8'd1, 16'd1, 8'd1}, -1, st);
`else
        no_txen("txen_empty_tail", 50);
`endif

        // Frame end with no bytes at all
        pulse_done();
`ifdef JPEG_PKT_HDR_EN
        mac_rx(1, 4, {8'd2, 16'd0, 8'd1}, -1, st);
`else
        no_txen("txen_empty_frame", 50);
`endif

        // Overfill with the MAC not ready
        i_mac_init_ready = 1'b0;
        fork
            push(5000, 4, 1'b0);
            no_txen("txen_mac_not_ready", 5020);
        join
        check("overflow_sticky", 32'(o_overflow), 32'd1);
        i_mac_init_ready = 1'b1;
        for (int k = 0; k < 4; k++)
            mac_rx(1, PM + H, {8'd3, 16'(k), 8'd0}, -1, st);
        check_payload(4, 4096);
        no_txen("txen_after_4096", 50);

        // Reset while mid-payload
        push(PM, 5, 1'b0);
        mac_rx(1, PM + H, {8'd3, 16'd4, 8'd0}, H + 300, st);
        check("stopped_mid_pay", 32'(st), 32'd1);
        check("de_mid_pay", 32'(o_udp_tx_de), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_tx_en", 32'(o_udp_tx_en), 32'd0);
        check("arst_tx_de", 32'(o_udp_tx_de), 32'd0);
        check("arst_data", 32'(o_udp_data), 32'd0);
        check("arst_len", 32'(o_udp_data_len), 32'd0);
        check("arst_sign", 32'(o_ipv4_sign), 32'd0);
        check("arst_overflow", 32'(o_overflow), 32'd0);
        check("arst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        i_byte_pass = 1'b0;
        i_udp_busy  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_sign = 16'd0;
        rx_q.delete();
        no_txen("txen_after_reset", 30);
        push(600, 6, 1'b1);
        mac_rx(1, 600 + H, {8'd0, 16'd0, 8'd1}, -1, st);
        check_payload(6, 600);

        // Slow MAC: one pass every third cycle
        push(PM, 7, 1'b1);
        mac_rx(3, PM + H, {8'd1, 16'd0, 8'd1}, -1, st);
        check("data_hold_violations", 32'(n_hold_bad), 32'd0);
        check_payload(7, PM);
        repeat (2) @(posedge clk);
        #1;
        check("frame_cnt_final", 32'(o_frame_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
